// File: rtl/gpu_fpu_sched.sv
// gpu_fpu_sched: shares one combinational FPU datapath between N_REQ requesters.
// Requesters are picked round-robin with valid/ready handshakes. The chosen opcode and
// operands are held on the FPU for a per-opcode number of cycles. The result is then
// returned tagged with the requester index.
// Optional feature macro: GPU_FPU_SCHED_PRIO_EN gives requester 0 fixed top priority.
module gpu_fpu_sched #(
    parameter int N_REQ     = 4,
    parameter int DATA_W    = 33,
    parameter int LAT_ADD   = 1,
    parameter int LAT_MUL   = 2,
    parameter int LAT_DIV   = 8,
    parameter int LAT_TRANS = 12,
    localparam int ID_W     = $clog2(N_REQ)
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [N_REQ-1:0]        req_valid,
    output logic [N_REQ-1:0]        req_ready,
    input  logic [6*N_REQ-1:0]      req_opc,
    input  logic [DATA_W*N_REQ-1:0] req_a,
    input  logic [DATA_W*N_REQ-1:0] req_b,
    output logic [5:0]              fpu_opc,
    output logic [DATA_W-1:0]       fpu_in1,
    output logic [DATA_W-1:0]       fpu_in2,
    input  logic [DATA_W-1:0]       fpu_out,
    output logic                    resp_valid,
    input  logic                    resp_ready,
    output logic [ID_W-1:0]         resp_id,
    output logic [DATA_W-1:0]       resp_data,
    output logic                    resp_err,
    output logic                    busy
);

    localparam int CNT_W = 16;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t            state;
    state_t            state_nxt;
    logic [ID_W-1:0]   rr_ptr;
    logic [CNT_W-1:0]  cnt;
    logic              bad_opc;
    logic              grant_any;
    logic [ID_W-1:0]   grant_idx;
    logic [5:0]        sel_opc;
    logic [DATA_W-1:0] sel_a;
    logic [DATA_W-1:0] sel_b;
    logic              sel_legal;
    logic              accept;
    logic [ID_W-1:0]   ptr_nxt;

    // Hold count for each legal opcode.
    function automatic logic [CNT_W-1:0] lat_of(input logic [5:0] opc);
        logic [CNT_W-1:0] lat;
        case (opc)
            6'd14, 6'd15: lat = CNT_W'(LAT_ADD);
            6'd16:        lat = CNT_W'(LAT_MUL);
            6'd17:        lat = CNT_W'(LAT_DIV);
            default:      lat = CNT_W'(LAT_TRANS);
        endcase
        return lat;
    endfunction

    // Pick the first valid requester at or after rr_ptr. Requester 0 may preempt this when
    // the priority option is built in.
    always_comb begin : arb
        logic [ID_W-1:0] cand;
        grant_any = 1'b0;
        grant_idx = '0;
        cand      = '0;
`ifdef GPU_FPU_SCHED_PRIO_EN
        if (req_valid[0]) begin
            grant_any = 1'b1;
        end
`endif
        for (int k = 0; k < N_REQ; k++) begin
            cand = ID_W'((int'(rr_ptr) + k) % N_REQ);
            if (!grant_any && req_valid[cand]) begin
                grant_any = 1'b1;
                grant_idx = cand;
            end
        end
    end

    assign sel_opc   = req_opc[int'(grant_idx)*6 +: 6];
    assign sel_a     = req_a[int'(grant_idx)*DATA_W +: DATA_W];
    assign sel_b     = req_b[int'(grant_idx)*DATA_W +: DATA_W];
    assign sel_legal = (sel_opc >= 6'd14) && (sel_opc <= 6'd22);
    assign accept    = (state == IDLE) && grant_any;
    assign ptr_nxt   = (grant_idx == ID_W'(N_REQ - 1)) ? '0 : grant_idx + 1'b1;

    assign resp_valid = (state == RESP);
    assign busy       = (state != IDLE);

    // One-hot ready toward the granted requester, only while idle and out of reset.
    always_comb begin
        req_ready = '0;
        if (!rst && accept) begin
            req_ready[grant_idx] = 1'b1;
        end
    end

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic. An illegal opcode also passes through one BUSY cycle.
    // This gives it the same one-cycle response timing as the fastest legal op.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (accept) state_nxt = BUSY;
            BUSY: if (cnt <= CNT_W'(1)) state_nxt = RESP;
            RESP: if (resp_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Datapath: latch the granted op, hold it, then capture and present the result.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rr_ptr    <= '0;
            cnt       <= '0;
            bad_opc   <= 1'b0;
            fpu_opc   <= '0;
            fpu_in1   <= '0;
            fpu_in2   <= '0;
            resp_id   <= '0;
            resp_data <= '0;
            resp_err  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        fpu_in1 <= sel_a;
                        fpu_in2 <= sel_b;
                        resp_id <= grant_idx;
`ifdef GPU_FPU_SCHED_PRIO_EN
                        if (grant_idx != '0) begin
                            rr_ptr <= ptr_nxt;
                        end
`else
                        rr_ptr <= ptr_nxt;
`endif
                        if (sel_legal) begin
                            fpu_opc <= sel_opc;
                            cnt     <= lat_of(sel_opc);
                            bad_opc <= 1'b0;
                        end else begin
                            fpu_opc <= '0;
                            cnt     <= CNT_W'(1);
                            bad_opc <= 1'b1;
                        end
                    end
                end
                BUSY: begin
                    cnt <= cnt - 1'b1;
                    if (cnt <= CNT_W'(1)) begin
                        resp_data <= bad_opc ? '0 : fpu_out;
                        resp_err  <= bad_opc;
                        fpu_opc   <= '0;
                    end
                end
                RESP: begin
                    if (resp_ready) begin
                        fpu_opc <= '0;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
